// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared constants for the multicycle MIPS datapath and control FSM
package mc_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_HOLD   = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

endpackage

// File: rtl/mc_en_reg.sv
// rtl/mc_en_reg.sv - W-bit register with synchronous active-high reset and load enable
module mc_en_reg #(
  parameter int W = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_ir_unit.sv
// rtl/pc_ir_unit.sv - PC/IR/MDR/ALUOut stage of the multicycle MIPS datapath
module pc_ir_unit #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0,
  parameter int CNT_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PCWrite,
  input  logic                  Branch,
  input  logic [1:0]            PCSrc,
  input  logic                  IorD,
  input  logic                  IRWrite,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic                  Zero,
  input  logic [DATA_WIDTH-1:0] MemRdData,
  output logic [DATA_WIDTH-1:0] MemAdr,
  output logic [DATA_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] Instr,
  output logic [DATA_WIDTH-1:0] Data,
  output logic [DATA_WIDTH-1:0] ALUOut,
  output logic                  PCEn,
  output logic [CNT_WIDTH-1:0]  InstrCount,
  output logic                  MisalignErr
);

  import mc_pkg::*;

  logic [DATA_WIDTH-1:0] pc_next;
  logic [DATA_WIDTH-1:0] pc_load;

  assign PCEn   = PCWrite | (Branch & Zero);
  assign MemAdr = IorD ? ALUOut : PC;

  always_comb begin
    pc_next = PC;
    case (PCSrc)
      PCSRC_ALU:    pc_next = ALUResult;
      PCSRC_ALUOUT: pc_next = ALUOut;
      PCSRC_JUMP:   pc_next = {PC[DATA_WIDTH-1:DATA_WIDTH-4], Instr[25:0], 2'b00};
      PCSRC_HOLD:   pc_next = PC;
      default:      pc_next = PC;
    endcase
  end

  // The PC itself is always kept word aligned; a bad target is only flagged.
  assign pc_load = {pc_next[DATA_WIDTH-1:2], 2'b00};

  mc_en_reg #(.W(DATA_WIDTH), .RST_VAL(RESET_PC)) u_pc (
    .clk(CLK), .rst(RST), .en(PCEn), .d(pc_load), .q(PC)
  );

  mc_en_reg #(.W(DATA_WIDTH), .RST_VAL('0)) u_ir (
    .clk(CLK), .rst(RST), .en(IRWrite), .d(MemRdData), .q(Instr)
  );

  mc_en_reg #(.W(DATA_WIDTH), .RST_VAL('0)) u_mdr (
    .clk(CLK), .rst(RST), .en(1'b1), .d(MemRdData), .q(Data)
  );

  mc_en_reg #(.W(DATA_WIDTH), .RST_VAL('0)) u_aluout (
    .clk(CLK), .rst(RST), .en(1'b1), .d(ALUResult), .q(ALUOut)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      InstrCount  <= '0;
      MisalignErr <= 1'b0;
    end else begin
      if (IRWrite) begin
        InstrCount <= InstrCount + CNT_WIDTH'(1);
      end
      if (PCEn && (pc_next[1:0] != 2'b00)) begin
        MisalignErr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_ir_unit.sv
// tb/tb_pc_ir_unit.sv - scoreboard bench for pc_ir_unit against a behavioural reference model
module tb_pc_ir_unit;

  logic        CLK = 1'b0;
  logic        RST, PCWrite, Branch, IorD, IRWrite, Zero;
  logic [1:0]  PCSrc;
  logic [31:0] ALUResult, MemRdData;
  logic [31:0] MemAdr, PC, Instr, Data, ALUOut, InstrCount;
  logic        PCEn, MisalignErr;

  pc_ir_unit dut (
    .CLK(CLK), .RST(RST), .PCWrite(PCWrite), .Branch(Branch), .PCSrc(PCSrc),
    .IorD(IorD), .IRWrite(IRWrite), .ALUResult(ALUResult), .Zero(Zero),
    .MemRdData(MemRdData), .MemAdr(MemAdr), .PC(PC), .Instr(Instr), .Data(Data),
    .ALUOut(ALUOut), .PCEn(PCEn), .InstrCount(InstrCount), .MisalignErr(MisalignErr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst, pcwrite, branch, zero, iord, irwrite;
    logic [1:0]  pcsrc;
    logic [31:0] alu_result, mem_rd;
  } stim_t;

  typedef struct {
    logic [31:0] memadr, pc, ir, mdr, aluout, cnt;
    logic        pcen, err;
  } obs_t;

  obs_t expq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: architectural state as plain integers
  logic [31:0] m_pc, m_ir, m_mdr, m_aluout, m_cnt;
  logic        m_err;
  bit          known = 0;
  logic [31:0] seen_memadr;
  logic        seen_pcen;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.pcwrite = 0; s.branch = 0; s.zero = 0; s.iord = 0; s.irwrite = 0;
    s.pcsrc = 2'b11; s.alu_result = 0; s.mem_rd = 0;
    return s;
  endfunction

  function automatic stim_t rand_stim(bit allow_rst);
    stim_t s;
    s.rst        = allow_rst && ($urandom_range(0, 49) == 0);
    s.pcwrite    = $urandom_range(0, 2) == 0;
    s.branch     = $urandom_range(0, 1) == 0;
    s.zero       = $urandom_range(0, 1) == 0;
    s.iord       = $urandom_range(0, 1) == 0;
    s.irwrite    = $urandom_range(0, 1) == 0;
    s.pcsrc      = 2'($urandom_range(0, 3));
    s.alu_result = $urandom;
    if ($urandom_range(0, 3) != 0) s.alu_result = s.alu_result & 32'hFFFF_FFFC;
    s.mem_rd     = $urandom;
    return s;
  endfunction

  // Called at posedge+1: drive, record expected view of this cycle, advance model, wait for edge.
  task automatic step(stim_t s);
    obs_t o;
    logic [31:0] target;
    logic        take;
    RST = s.rst; PCWrite = s.pcwrite; Branch = s.branch; Zero = s.zero; IorD = s.iord;
    IRWrite = s.irwrite; PCSrc = s.pcsrc; ALUResult = s.alu_result; MemRdData = s.mem_rd;
    take = s.pcwrite || (s.branch && s.zero);
    case (s.pcsrc)
      2'd0:    target = s.alu_result;
      2'd1:    target = m_aluout;
      2'd2:    target = (m_pc & 32'hF000_0000) + (m_ir & 32'h03FF_FFFF) * 4;
      default: target = m_pc;
    endcase
    o.memadr = s.iord ? m_aluout : m_pc;
    o.pcen = take; o.pc = m_pc; o.ir = m_ir; o.mdr = m_mdr;
    o.aluout = m_aluout; o.cnt = m_cnt; o.err = m_err;
    if (known) expq.push_back(o);
    if (s.rst) begin
      m_pc = 0; m_ir = 0; m_mdr = 0; m_aluout = 0; m_cnt = 0; m_err = 0;
      known = 1;
    end else begin
      if (take) begin
        m_pc = target - (target % 4);
        if (target % 4 != 0) m_err = 1;
      end
      if (s.irwrite) begin
        m_ir  = s.mem_rd;
        m_cnt = m_cnt + 1;
      end
      m_mdr    = s.mem_rd;
      m_aluout = s.alu_result;
    end
    #2;
    seen_memadr = MemAdr;
    seen_pcen   = PCEn;
    @(posedge CLK);
    #1;
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge CLK);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("MemAdr",      MemAdr,      e.memadr);
        check("PCEn",        32'(PCEn),   32'(e.pcen));
        check("PC",          PC,          e.pc);
        check("Instr",       Instr,       e.ir);
        check("Data",        Data,        e.mdr);
        check("ALUOut",      ALUOut,      e.aluout);
        check("InstrCount",  InstrCount,  e.cnt);
        check("MisalignErr", 32'(MisalignErr), 32'(e.err));
      end
    end
  end

  initial begin : driver
    stim_t s;
    m_pc = 0; m_ir = 0; m_mdr = 0; m_aluout = 0; m_cnt = 0; m_err = 0;
    @(posedge CLK);
    #1;
    // Reset for two cycles under random inputs
    for (int i = 0; i < 2; i++) begin
      s = rand_stim(0); s.rst = 1; step(s);
    end
    check("reset_pc", PC, 32'h0);
    check("reset_instr", Instr, 32'h0);
    check("reset_cnt", InstrCount, 32'h0);
    check("reset_err", 32'(MisalignErr), 32'h0);

    // Fetch
    s = idle(); s.mem_rd = 32'h8C41_0004; s.irwrite = 1; s.pcwrite = 1; s.pcsrc = 2'b00;
    s.alu_result = 32'd4; step(s);
    check("fetch_memadr", seen_memadr, 32'h0);
    check("fetch_instr", Instr, 32'h8C41_0004);
    check("fetch_pc", PC, 32'h4);
    check("fetch_cnt", InstrCount, 32'h1);

    // Branch: not taken then taken
    s = idle(); s.alu_result = 32'h40; step(s);
    s = idle(); s.branch = 1; s.pcsrc = 2'b01; s.zero = 0; s.alu_result = 32'h40; step(s);
    check("bnt_pcen", 32'(seen_pcen), 32'h0);
    check("bnt_pc", PC, 32'h4);
    s.zero = 1; step(s);
    check("bt_pc", PC, 32'h40);

    // Jump
    s = idle(); s.pcwrite = 1; s.pcsrc = 2'b00; s.alu_result = 32'h1000_0008;
    s.irwrite = 1; s.mem_rd = 32'h0800_0010; step(s);
    s = idle(); s.pcwrite = 1; s.pcsrc = 2'b10; step(s);
    check("jump_pc", PC, 32'h1000_0040);

    // Hold select keeps PC even with PCWrite
    s = idle(); s.pcwrite = 1; s.pcsrc = 2'b11; s.alu_result = 32'h0000_0104; step(s);
    check("hold_pc", PC, 32'h1000_0040);

    // Load address through ALUOut
    s = idle(); s.iord = 1; s.mem_rd = 32'hDEAD_BEEF; step(s);
    check("load_memadr", seen_memadr, 32'h104);
    check("load_data", Data, 32'hDEAD_BEEF);

    // Misaligned target, sticky flag, reset mid-instruction
    s = idle(); s.pcwrite = 1; s.pcsrc = 2'b00; s.alu_result = 32'h6; step(s);
    check("mis_pc", PC, 32'h4);
    check("mis_err", 32'(MisalignErr), 32'h1);
    s.alu_result = 32'h8; step(s);
    check("mis_sticky", 32'(MisalignErr), 32'h1);
    s = rand_stim(0); s.rst = 1; step(s);
    check("rst_pc", PC, 32'h0);
    check("rst_err", 32'(MisalignErr), 32'h0);
    check("rst_cnt", InstrCount, 32'h0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      s = rand_stim(1); step(s);
    end

    s = idle(); step(s);
    @(posedge CLK);
    #1;
    check("scoreboard_drained", 32'(expq.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
